pipe_control: RTL
=================

PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk_i rising edge only; rst_i sampled on clk_i.
REQ-002 Parameter MD_LATENCY, default 4: cycles (1..15) that ID stays stalled after a mult/div issues.
REQ-003 Parameter BR_BUBBLES, default 1: bubbles (0..3) inserted after a beq/bne issues; 0 = pure delay-slot mode.
REQ-004 Parameter ALU_CTL_W, default 6: width of ALUCtl_o; ALU_CTL_*, ALU_SRC_*, REG_DST_* encodings come from Def.v.
REQ-005 Ports:
- clk_i  in  1  clock
- rst_i  in  1  sync reset, active high
- IdValid_i  in  1  ID holds a real instruction
- Opcode_i, Funct_i  in  6 each  ID instruction fields
- Rs_i, Rt_i  in  5 each  ID source registers
- ExMemRead_i  in  1  EX instruction is a load
- ExRt_i  in  5  EX load destination
- HoldExt_i  in  1  external freeze (cache miss)
- RegDst_o, ALUSrc1_o, ALUSrc2_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Beq_o, Bne_o, JumpImm_o, JumpReg_o, Link_o  out  1 each  decoded controls
- MdOp_o  out  2  00 none, 01 mult, 10 div
- ALUCtl_o  out  ALU_CTL_W  ALU operation
- Stall_o  out  1  freeze PC and IF/ID
- Bubble_o  out  1  force zero controls into ID/EX
- Illegal_o  out  1  unsupported opcode/funct in ID
- Busy_o  out  1  FSM not in RUN

Function
REQ-006 Decode SHALL be combinational: R-type sll/srl/sra/jr/jalr/add/sub/and/or/xor/nor/slt, plus mult (funct 011000), div (011010), j, jal, beq, bne, addi, andi, ori, xori, slti, lw, sw.
REQ-007 Defaults SHALL be RegDst=RD, ALUSrc1/2=REG, ALUCtl=ADD, all other controls 0; jal/jalr SHALL use ALUSrc1=PC, Link=1, RegWrite=1; mult/div SHALL drive MdOp_o with RegWrite=0.
REQ-008 Unknown opcode or funct with IdValid_i=1 SHALL drive Illegal_o=1 with all write/mem/branch/jump controls 0.
REQ-009 When IdValid_i=0 or Bubble_o=1, all control outputs except ALUCtl_o (ADD) SHALL be 0, and Illegal_o SHALL be 0.
REQ-010 FSM states SHALL be RUN, BR_WAIT, MD_WAIT, with down-counter cnt of 4 bits.
REQ-011 An instruction issues when state=RUN, IdValid_i=1, Stall_o=0.
REQ-012 RUN->BR_WAIT on issue of beq/bne when BR_BUBBLES>0, cnt<=BR_BUBBLES-1; RUN->MD_WAIT on issue of mult/div, cnt<=MD_LATENCY-1.
REQ-013 In BR_WAIT/MD_WAIT: Stall_o=1, Bubble_o=1, Busy_o=1; cnt decrements each unfrozen cycle; cnt=0 -> RUN next edge.
REQ-014 Load-use in RUN: ExMemRead_i=1, ExRt_i!=0, and ExRt_i equals Rs_i or (instruction reads rt: R-type, beq, bne, sw) Rt_i, SHALL assert Stall_o=1, Bubble_o=1 for that cycle only; no issue, no transition.
REQ-015 HoldExt_i=1 SHALL force Stall_o=1, Bubble_o=0, freeze state and cnt, and block issue.
REQ-016 Priority SHALL be rst_i > HoldExt_i > BR_WAIT/MD_WAIT > load-use > issue.
REQ-017 Back-to-back: a branch or mult/div in ID during a wait state SHALL issue on the first RUN cycle, not earlier.
REQ-018 j/jal/jr/jalr SHALL issue with no stall (branch delay slot).

Reset
REQ-019 rst_i=1 SHALL set state=RUN, cnt=0 on the next edge, overriding HoldExt_i and any wait in progress.
REQ-020 After reset with IdValid_i=0: Stall_o=0, Bubble_o=0, Busy_o=0, Illegal_o=0, MdOp_o=00, all 1-bit controls 0.

Verification
REQ-021 add $3,$1,$2 valid, no hazard -> RegWrite=1, ALUCtl=ADD, RegDst=RD, Stall_o=0 same cycle.
REQ-022 beq with BR_BUBBLES=1 -> issue cycle Beq_o=1, Stall_o=0; next cycle Stall_o=1, Bubble_o=1; following cycle RUN.
REQ-023 mult with MD_LATENCY=4 -> MdOp_o=01 on issue, then exactly 4 cycles Stall_o=Bubble_o=Busy_o=1.
REQ-024 ExMemRead_i=1, ExRt_i=5, ID sw with Rt_i=5 -> 1-cycle stall+bubble; with ExRt_i=0 -> no stall.
REQ-025 MD_WAIT cnt=2 with HoldExt_i=1 for 3 cycles -> cnt stays 2, Bubble_o=0; release -> 3 more stalled cycles.
REQ-026 rst_i mid MD_WAIT -> next cycle RUN, Busy_o=0; opcode 111111 valid -> Illegal_o=1, RegWrite=0.

Source files
------------

// File: rtl/pipe_control.sv
// rtl/pipe_control.sv - ID-stage decode plus branch/mult-div/load-use stall control
module pipe_control #(
  parameter int MD_LATENCY = 4,
  parameter int BR_BUBBLES = 1,
  parameter int ALU_CTL_W  = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 IdValid_i,
  input  logic [5:0]           Opcode_i,
  input  logic [5:0]           Funct_i,
  input  logic [4:0]           Rs_i,
  input  logic [4:0]           Rt_i,
  input  logic                 ExMemRead_i,
  input  logic [4:0]           ExRt_i,
  input  logic                 HoldExt_i,
  output logic                 RegDst_o,
  output logic                 ALUSrc1_o,
  output logic                 ALUSrc2_o,
  output logic                 RegWrite_o,
  output logic                 MemToReg_o,
  output logic                 MemRead_o,
  output logic                 MemWrite_o,
  output logic                 Beq_o,
  output logic                 Bne_o,
  output logic                 JumpImm_o,
  output logic                 JumpReg_o,
  output logic                 Link_o,
  output logic [1:0]           MdOp_o,
  output logic [ALU_CTL_W-1:0] ALUCtl_o,
  output logic                 Stall_o,
  output logic                 Bubble_o,
  output logic                 Illegal_o,
  output logic                 Busy_o
);

  localparam logic [ALU_CTL_W-1:0] ALU_CTL_ADD = ALU_CTL_W'(0);
  localparam logic [ALU_CTL_W-1:0] ALU_CTL_SUB = ALU_CTL_W'(1);
  localparam logic [ALU_CTL_W-1:0] ALU_CTL_AND = ALU_CTL_W'(2);
  localparam logic [ALU_CTL_W-1:0] ALU_CTL_OR  = ALU_CTL_W'(3);
  localparam logic [ALU_CTL_W-1:0] ALU_CTL_XOR = ALU_CTL_W'(4);
  localparam logic [ALU_CTL_W-1:0] ALU_CTL_NOR = ALU_CTL_W'(5);
  localparam logic [ALU_CTL_W-1:0] ALU_CTL_SLT = ALU_CTL_W'(6);
  localparam logic [ALU_CTL_W-1:0] ALU_CTL_SLL = ALU_CTL_W'(7);
  localparam logic [ALU_CTL_W-1:0] ALU_CTL_SRL = ALU_CTL_W'(8);
  localparam logic [ALU_CTL_W-1:0] ALU_CTL_SRA = ALU_CTL_W'(9);
  localparam logic REG_DST_RD  = 1'b0;
  localparam logic REG_DST_RT  = 1'b1;
  localparam logic ALU_SRC_REG = 1'b0;
  localparam logic ALU_SRC_PC  = 1'b1;
  localparam logic ALU_SRC_IMM = 1'b1;
  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  typedef enum logic [1:0] {ST_RUN, ST_BR_WAIT, ST_MD_WAIT} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 d_reg_dst, d_src1, d_src2, d_reg_write, d_mem_to_reg, d_mem_read;
  logic                 d_mem_write, d_beq, d_bne, d_jump_imm, d_jump_reg, d_link;
  logic [1:0]           d_md;
  logic [ALU_CTL_W-1:0] d_alu;
  logic                 d_legal, d_reads_rt;
  logic                 in_wait, load_use, issue, kill;

  always_comb begin
    d_reg_dst = REG_DST_RD;  d_src1 = ALU_SRC_REG;  d_src2 = ALU_SRC_REG;
    d_reg_write = 1'b0;  d_mem_to_reg = 1'b0;  d_mem_read = 1'b0;  d_mem_write = 1'b0;
    d_beq = 1'b0;  d_bne = 1'b0;  d_jump_imm = 1'b0;  d_jump_reg = 1'b0;  d_link = 1'b0;
    d_md = MD_NONE;  d_alu = ALU_CTL_ADD;  d_legal = 1'b1;  d_reads_rt = 1'b0;
    case (Opcode_i)
      6'b000000: begin
        d_reads_rt  = 1'b1;
        d_reg_write = 1'b1;
        case (Funct_i)
          6'b000000: d_alu = ALU_CTL_SLL;
          6'b000010: d_alu = ALU_CTL_SRL;
          6'b000011: d_alu = ALU_CTL_SRA;
          6'b001000: begin d_reg_write = 1'b0; d_jump_reg = 1'b1; end
          6'b001001: begin d_jump_reg = 1'b1; d_link = 1'b1; d_src1 = ALU_SRC_PC; end
          6'b011000: begin d_reg_write = 1'b0; d_md = MD_MULT; end
          6'b011010: begin d_reg_write = 1'b0; d_md = MD_DIV; end
          6'b100000: d_alu = ALU_CTL_ADD;
          6'b100010: d_alu = ALU_CTL_SUB;
          6'b100100: d_alu = ALU_CTL_AND;
          6'b100101: d_alu = ALU_CTL_OR;
          6'b100110: d_alu = ALU_CTL_XOR;
          6'b100111: d_alu = ALU_CTL_NOR;
          6'b101010: d_alu = ALU_CTL_SLT;
          default:   d_legal = 1'b0;
        endcase
      end
      6'b000010: d_jump_imm = 1'b1;
      6'b000011: begin d_jump_imm = 1'b1; d_link = 1'b1; d_reg_write = 1'b1; d_src1 = ALU_SRC_PC; end
      6'b000100: begin d_beq = 1'b1; d_alu = ALU_CTL_SUB; d_reads_rt = 1'b1; end
      6'b000101: begin d_bne = 1'b1; d_alu = ALU_CTL_SUB; d_reads_rt = 1'b1; end
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: begin
        d_reg_write = 1'b1; d_reg_dst = REG_DST_RT; d_src2 = ALU_SRC_IMM;
        case (Opcode_i)
          6'b001010: d_alu = ALU_CTL_SLT;
          6'b001100: d_alu = ALU_CTL_AND;
          6'b001101: d_alu = ALU_CTL_OR;
          6'b001110: d_alu = ALU_CTL_XOR;
          default:   d_alu = ALU_CTL_ADD;
        endcase
      end
      6'b100011: begin
        d_reg_write = 1'b1; d_reg_dst = REG_DST_RT; d_src2 = ALU_SRC_IMM;
        d_mem_read = 1'b1; d_mem_to_reg = 1'b1;
      end
      6'b101011: begin d_mem_write = 1'b1; d_src2 = ALU_SRC_IMM; d_reads_rt = 1'b1; end
      default:   d_legal = 1'b0;
    endcase
  end

  // Hold freezes everything but must not squash the ID instruction, so it stalls without a bubble.
  assign in_wait  = (state_q != ST_RUN);
  assign load_use = !in_wait && IdValid_i && ExMemRead_i && (ExRt_i != 5'd0) &&
                    ((ExRt_i == Rs_i) || (d_reads_rt && (ExRt_i == Rt_i)));
  assign Stall_o  = HoldExt_i || in_wait || load_use;
  assign Bubble_o = !HoldExt_i && (in_wait || load_use);
  assign Busy_o   = in_wait;
  assign issue    = !in_wait && IdValid_i && !Stall_o;

  assign kill      = !IdValid_i || Bubble_o || !d_legal;
  assign Illegal_o = IdValid_i && !Bubble_o && !d_legal;
  assign {RegDst_o, ALUSrc1_o, ALUSrc2_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o,
          Beq_o, Bne_o, JumpImm_o, JumpReg_o, Link_o} = kill ? 12'd0 :
         {d_reg_dst, d_src1, d_src2, d_reg_write, d_mem_to_reg, d_mem_read, d_mem_write,
          d_beq, d_bne, d_jump_imm, d_jump_reg, d_link};
  assign MdOp_o   = kill ? MD_NONE : d_md;
  assign ALUCtl_o = kill ? ALU_CTL_ADD : d_alu;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!HoldExt_i) begin
      if (in_wait) begin
        if (cnt_q == 4'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end else if (issue && d_legal && (d_beq || d_bne) && (BR_BUBBLES > 0)) begin
        state_d = ST_BR_WAIT;
        cnt_d   = 4'(BR_BUBBLES - 1);
      end else if (issue && d_legal && (d_md != MD_NONE)) begin
        state_d = ST_MD_WAIT;
        cnt_d   = 4'(MD_LATENCY - 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
